// File: rtl/uart_rx_oversample.sv
// Oversampling 8N1-style UART receiver driven by an external s_tick strobe.
// Recovers one data word per frame and flags a low stop bit.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | line high, waiting for a synchronized falling edge
// START   | counting to mid start bit to confirm it is not a glitch
// DATA    | sampling DBIT data bits mid-bit, LSB first
// STOP    | waiting SB_TICK ticks, then publishing the word
module uart_rx_oversample #(
  parameter int DBIT    = 8,
  parameter int SAMPLE  = 32,
  parameter int SB_TICK = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            busy
);

  localparam int S_MAX = (SAMPLE > SB_TICK) ? SAMPLE : SB_TICK;
  localparam int SW    = (S_MAX > 1) ? $clog2(S_MAX) : 1;
  localparam int NW    = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_HALF_LAST = SW'(SAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_BIT_LAST  = SW'(SAMPLE - 1);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  state_t          r_state;
  logic [SW-1:0]   r_s;
  logic [NW-1:0]   r_n;
  logic [DBIT-1:0] r_b;
  logic [DBIT-1:0] r_dout;
  logic            r_done;
  logic            r_ferr;
  logic            r_busy;
  logic            r_rx_meta;
  logic            r_rx_s;

  // rx is asynchronous; both stages reset to the idle (high) level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_dout  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_ferr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!r_rx_s) begin
            r_state <= ST_START;
            r_s     <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_START: begin
          if (s_tick) begin
            if (r_s == S_HALF_LAST) begin
              if (!r_rx_s) begin
                r_state <= ST_DATA;
                r_s     <= '0;
                r_n     <= '0;
              end else begin
                // line went back high before mid start bit: glitch
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_s <= r_s + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (s_tick) begin
            if (r_s == S_BIT_LAST) begin
              r_s <= '0;
              r_b <= {r_rx_s, r_b[DBIT-1:1]};
              if (r_n == N_LAST) begin
                r_state <= ST_STOP;
              end else begin
                r_n <= r_n + 1'b1;
              end
            end else begin
              r_s <= r_s + 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (s_tick) begin
            if (r_s == S_STOP_LAST) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_dout  <= r_b;
              r_done  <= 1'b1;
              r_ferr  <= ~r_rx_s;
            end else begin
              r_s <= r_s + 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dout         = r_dout;
  assign rx_done_tick = r_done;
  assign frame_err    = r_ferr;
  assign busy         = r_busy;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample: frames are driven bit by bit on rx
// and each scenario task checks captured done pulses against fixed bytes.
module tb_uart_rx_oversample;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic       s_tick = 1'b0;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  int div = 4;
  int tcnt = 0;

  int         done_cnt = 0;
  int         ferr_orphan = 0;
  logic [7:0] cap_dout[$];
  logic       cap_ferr[$];
  logic       busy_after = 1'b1;
  logic       prev_done = 1'b0;

  uart_rx_oversample #(.DBIT(8), .SAMPLE(32), .SB_TICK(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx           (rx),
    .s_tick       (s_tick),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tcnt >= div - 1) begin
      tcnt   = 0;
      s_tick = 1'b1;
    end else begin
      tcnt   = tcnt + 1;
      s_tick = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (prev_done) busy_after = busy;
      prev_done = rx_done_tick;
      if (rx_done_tick) begin
        done_cnt = done_cnt + 1;
        cap_dout.push_back(dout);
        cap_ferr.push_back(frame_err);
      end
      if (frame_err && !rx_done_tick) ferr_orphan = ferr_orphan + 1;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic hold(input logic v, input int ticks);
    rx = v;
    repeat (ticks * div) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_val, input int stop_ticks);
    hold(1'b0, 32);
    for (int i = 0; i < 8; i++) hold(d[i], 32);
    hold(stop_val, stop_ticks);
    rx = 1'b1;
  endtask

  function automatic logic [7:0] cap_byte(input int idx);
    if (cap_dout.size() > idx) return cap_dout[idx];
    return 8'hxx;
  endfunction

  function automatic logic cap_fe(input int idx);
    if (cap_ferr.size() > idx) return cap_ferr[idx];
    return 1'bx;
  endfunction

  task automatic test_reset();
    repeat (4) @(negedge clk);
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", dout); end
    checks++; if (rx_done_tick !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", rx_done_tick); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_single_55();
    int base;
    base = done_cnt;
    busy_after = 1'b1;
    send_frame(8'h55, 1'b1, 32);
    repeat (200) @(negedge clk);
    checks++; if (done_cnt - base !== 1) begin errors++; $display("FAIL f55_count: got %0d expected 1", done_cnt - base); end
    checks++; if (cap_byte(base) !== 8'h55) begin errors++; $display("FAIL f55_dout: got %h expected 55", cap_byte(base)); end
    checks++; if (cap_fe(base) !== 1'b0) begin errors++; $display("FAIL f55_ferr: got %b expected 0", cap_fe(base)); end
    checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL f55_busy_after: got %b expected 0", busy_after); end
  endtask

  task automatic test_back_to_back();
    int base;
    base = done_cnt;
    send_frame(8'hA3, 1'b1, 32);
    send_frame(8'h0F, 1'b1, 32);
    repeat (200) @(negedge clk);
    checks++; if (done_cnt - base !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", done_cnt - base); end
    checks++; if (cap_byte(base) !== 8'hA3) begin errors++; $display("FAIL b2b_dout0: got %h expected a3", cap_byte(base)); end
    checks++; if (cap_byte(base + 1) !== 8'h0F) begin errors++; $display("FAIL b2b_dout1: got %h expected 0f", cap_byte(base + 1)); end
    checks++; if (cap_fe(base) !== 1'b0) begin errors++; $display("FAIL b2b_ferr0: got %b expected 0", cap_fe(base)); end
    checks++; if (cap_fe(base + 1) !== 1'b0) begin errors++; $display("FAIL b2b_ferr1: got %b expected 0", cap_fe(base + 1)); end
  endtask

  task automatic test_glitch();
    int base;
    base = done_cnt;
    rx = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_rise: got %b expected 1", busy); end
    repeat (32) @(negedge clk);
    rx = 1'b1;
    repeat (150) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_fall: got %b expected 0", busy); end
    checks++; if (done_cnt !== base) begin errors++; $display("FAIL glitch_done: got %0d expected %0d", done_cnt, base); end
    checks++; if (dout !== 8'h0F) begin errors++; $display("FAIL glitch_dout: got %h expected 0f", dout); end
  endtask

  task automatic test_frame_error();
    int base;
    base = done_cnt;
    // stop held low just past its mid point, then the line idles high
    send_frame(8'hC6, 1'b0, 20);
    repeat (300) @(negedge clk);
    checks++; if (done_cnt - base !== 1) begin errors++; $display("FAIL ferr_count: got %0d expected 1", done_cnt - base); end
    checks++; if (cap_fe(base) !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b expected 1", cap_fe(base)); end
    checks++; if (cap_byte(base) !== 8'hC6) begin errors++; $display("FAIL ferr_dout: got %h expected c6", cap_byte(base)); end
    checks++; if (ferr_orphan !== 0) begin errors++; $display("FAIL ferr_orphan: got %0d expected 0", ferr_orphan); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_idle: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    logic [7:0] d;
    d = 8'h3C;
    base = done_cnt;
    hold(1'b0, 32);
    for (int i = 0; i < 4; i++) hold(d[i], 32);
    rx = d[4];
    repeat (16 * div) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before: got %b expected 1", busy); end
    reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL rst_mid_dout: got %h expected 00", dout); end
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (400) @(negedge clk);
    checks++; if (done_cnt !== base) begin errors++; $display("FAIL rst_mid_no_done: got %0d expected %0d", done_cnt, base); end
    send_frame(8'h81, 1'b1, 32);
    repeat (200) @(negedge clk);
    checks++; if (done_cnt - base !== 1) begin errors++; $display("FAIL rst_after_count: got %0d expected 1", done_cnt - base); end
    checks++; if (cap_byte(base) !== 8'h81) begin errors++; $display("FAIL rst_after_dout: got %h expected 81", cap_byte(base)); end
    checks++; if (cap_fe(base) !== 1'b0) begin errors++; $display("FAIL rst_after_ferr: got %b expected 0", cap_fe(base)); end
  endtask

  task automatic test_tick_every_cycle();
    int base;
    div = 1;
    repeat (20) @(negedge clk);
    base = done_cnt;
    send_frame(8'hFF, 1'b1, 32);
    send_frame(8'h00, 1'b1, 32);
    repeat (100) @(negedge clk);
    checks++; if (done_cnt - base !== 2) begin errors++; $display("FAIL fast_count: got %0d expected 2", done_cnt - base); end
    checks++; if (cap_byte(base) !== 8'hFF) begin errors++; $display("FAIL fast_dout0: got %h expected ff", cap_byte(base)); end
    checks++; if (cap_byte(base + 1) !== 8'h00) begin errors++; $display("FAIL fast_dout1: got %h expected 00", cap_byte(base + 1)); end
    checks++; if (cap_fe(base) !== 1'b0) begin errors++; $display("FAIL fast_ferr0: got %b expected 0", cap_fe(base)); end
    checks++; if (cap_fe(base + 1) !== 1'b0) begin errors++; $display("FAIL fast_ferr1: got %b expected 0", cap_fe(base + 1)); end
  endtask

  initial begin
    test_reset();
    test_single_55();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_mid_frame();
    test_tick_every_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
